// File: rtl/alu_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_arbiter_pkg
// Brief    : Shared constants, types and helpers for the two-port ALU arbiter.
//            Holds the funct3 op codes, the funct7 alternate-op bit and the
//            flag bit positions.
// Revision : 1.0 - initial release
// ============================================================================
package alu_rr_arbiter_pkg;

    // funct3 op-select encodings
    localparam logic [2:0] c_f3_add  = 3'b000;
    localparam logic [2:0] c_f3_sll  = 3'b001;
    localparam logic [2:0] c_f3_slt  = 3'b010;
    localparam logic [2:0] c_f3_sltu = 3'b011;
    localparam logic [2:0] c_f3_xor  = 3'b100;
    localparam logic [2:0] c_f3_sr   = 3'b101;
    localparam logic [2:0] c_f3_or   = 3'b110;
    localparam logic [2:0] c_f3_and  = 3'b111;

    // funct7 bit that selects SUB / SRA
    localparam int c_funct7_alt = 5;

    // Bit positions inside the {V,C,N,Z} flag vector
    localparam int c_flag_v = 3;
    localparam int c_flag_c = 2;
    localparam int c_flag_n = 1;
    localparam int c_flag_z = 0;

    typedef logic [3:0] flags_t;

    // The adder subtracts for the alternate op and for both compares,
    // because SLT/SLTU derive their answer from the subtraction flags.
    function automatic logic alu_uses_sub(input logic funct7_alt, input logic [2:0] funct3);
        return funct7_alt | (funct3 == c_f3_slt) | (funct3 == c_f3_sltu);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_arbiter_if
// Brief    : Request/response bundle for the two requesters sharing the ALU.
//            master = requester side, slave = arbiter side.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_rr_arbiter_if #(
    parameter int TAG_W = 2
);
    import alu_rr_arbiter_pkg::*;

    // Requester 0
    logic             req0_valid;
    logic             req0_ready;
    logic [6:0]       req0_funct7;
    logic [2:0]       req0_funct3;
    logic [31:0]      req0_a;
    logic [31:0]      req0_b;
    logic [TAG_W-1:0] req0_tag;
    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [31:0]      rsp0_result;
    flags_t           rsp0_flags;
    logic [TAG_W-1:0] rsp0_tag;

    // Requester 1
    logic             req1_valid;
    logic             req1_ready;
    logic [6:0]       req1_funct7;
    logic [2:0]       req1_funct3;
    logic [31:0]      req1_a;
    logic [31:0]      req1_b;
    logic [TAG_W-1:0] req1_tag;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [31:0]      rsp1_result;
    flags_t           rsp1_flags;
    logic [TAG_W-1:0] rsp1_tag;

    modport master (
        output req0_valid, req0_funct7, req0_funct3, req0_a, req0_b, req0_tag, rsp0_ready,
        output req1_valid, req1_funct7, req1_funct3, req1_a, req1_b, req1_tag, rsp1_ready,
        input  req0_ready, rsp0_valid, rsp0_result, rsp0_flags, rsp0_tag,
        input  req1_ready, rsp1_valid, rsp1_result, rsp1_flags, rsp1_tag
    );

    modport slave (
        input  req0_valid, req0_funct7, req0_funct3, req0_a, req0_b, req0_tag, rsp0_ready,
        input  req1_valid, req1_funct7, req1_funct3, req1_a, req1_b, req1_tag, rsp1_ready,
        output req0_ready, rsp0_valid, rsp0_result, rsp0_flags, rsp0_tag,
        output req1_ready, rsp1_valid, rsp1_result, rsp1_flags, rsp1_tag
    );

endinterface
`default_nettype wire

// File: rtl/alu_rr_arbiter_alu.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_arbiter_alu
// Brief    : Combinational RV32 integer ALU. Flags {V,C,N,Z} always come from
//            the adder path regardless of the selected op.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rr_arbiter_alu
    import alu_rr_arbiter_pkg::*;
(
    input  wire logic [6:0]  i_funct7,
    input  wire logic [2:0]  i_funct3,
    input  wire logic [31:0] i_a,
    input  wire logic [31:0] i_b,
    output logic      [31:0] o_result,
    output flags_t           o_flags
);

    logic        w_sub;
    logic [31:0] w_b_eff;
    logic [32:0] w_sum;
    logic        w_v;
    logic        w_c;
    logic        w_n;
    logic        w_z;
    logic        w_unused_funct7;

    // Only the alternate-op bit of funct7 carries meaning here
    assign w_unused_funct7 = ^{i_funct7[6], i_funct7[4:0]};

    // Shared adder: subtraction is A + ~B + 1, so carry out means "no borrow"
    assign w_sub   = alu_uses_sub(i_funct7[c_funct7_alt], i_funct3);
    assign w_b_eff = i_b ^ {32{w_sub}};
    assign w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {32'd0, w_sub};

    assign w_c = w_sum[32];
    assign w_n = w_sum[31];
    assign w_z = (w_sum[31:0] == 32'd0);
    assign w_v = (i_a[31] == w_b_eff[31]) & (w_sum[31] != i_a[31]);

    // Flag vector assembly
    always_comb begin
        o_flags           = '0;
        o_flags[c_flag_v] = w_v;
        o_flags[c_flag_c] = w_c;
        o_flags[c_flag_n] = w_n;
        o_flags[c_flag_z] = w_z;
    end

    // Result select by funct3
    always_comb begin
        o_result = w_sum[31:0];
        case (i_funct3)
            c_f3_add:  o_result = w_sum[31:0];
            c_f3_sll:  o_result = i_a << i_b[4:0];
            c_f3_slt:  o_result = {31'd0, w_n ^ w_v};
            c_f3_sltu: o_result = {31'd0, ~w_c};
            c_f3_xor:  o_result = i_a ^ i_b;
            c_f3_sr:   o_result = i_funct7[c_funct7_alt] ? 32'($signed(i_a) >>> i_b[4:0])
                                                         : (i_a >> i_b[4:0]);
            c_f3_or:   o_result = i_a | i_b;
            c_f3_and:  o_result = i_a & i_b;
            default:   o_result = w_sum[31:0];
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_rr_arbiter_rr_grant2.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_arbiter_rr_grant2
// Brief    : Two-way round-robin grant. On a tie the requester that was not
//            granted last wins; otherwise the single eligible one wins.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rr_arbiter_rr_grant2 (
    input  wire logic [1:0] i_elig,
    input  wire logic       i_last_grant,
    output logic            o_grant_valid,
    output logic            o_grant
);

    // Grant decision from eligibility and last-grant pointer
    always_comb begin
        o_grant_valid = |i_elig;
        o_grant       = (&i_elig) ? ~i_last_grant : i_elig[1];
    end

endmodule
`default_nettype wire

// File: rtl/alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_arbiter
// Brief    : Shares one ALU between two valid/ready requesters. Round-robin
//            grant, combinational ALU, one registered response slot per
//            requester. One op per cycle, one cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rr_arbiter
    import alu_rr_arbiter_pkg::*;
#(
    parameter int TAG_W      = 2,
    parameter bit RESET_LAST = 1'b1
) (
    input wire logic        clk,
    input wire logic        rst,
    alu_rr_arbiter_if.slave bus
);

    logic [1:0]       w_elig;
    logic             w_grant_valid;
    logic             w_grant;
    logic             w_sel1;
    logic             w_hs0;
    logic             w_hs1;
    logic [6:0]       w_alu_funct7;
    logic [2:0]       w_alu_funct3;
    logic [31:0]      w_alu_a;
    logic [31:0]      w_alu_b;
    logic [31:0]      w_alu_result;
    flags_t           w_alu_flags;

    logic             r_last_grant;
    logic             r_rsp0_valid;
    logic [31:0]      r_rsp0_result;
    flags_t           r_rsp0_flags;
    logic [TAG_W-1:0] r_rsp0_tag;
    logic             r_rsp1_valid;
    logic [31:0]      r_rsp1_result;
    flags_t           r_rsp1_flags;
    logic [TAG_W-1:0] r_rsp1_tag;

    // A slot being drained this cycle counts as free, so back-to-back ops
    // into the same slot never bubble.
    assign w_elig[0] = bus.req0_valid & (~r_rsp0_valid | bus.rsp0_ready);
    assign w_elig[1] = bus.req1_valid & (~r_rsp1_valid | bus.rsp1_ready);

    alu_rr_arbiter_rr_grant2 u_grant (
        .i_elig        (w_elig),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_grant_valid),
        .o_grant       (w_grant)
    );

    assign bus.req0_ready = w_grant_valid & ~w_grant;
    assign bus.req1_ready = w_grant_valid &  w_grant;

    assign w_hs0 = bus.req0_valid & bus.req0_ready;
    assign w_hs1 = bus.req1_valid & bus.req1_ready;

    // Operand mux; defaults to requester 0 when idle (result discarded)
    assign w_sel1       = w_grant_valid & w_grant;
    assign w_alu_funct7 = w_sel1 ? bus.req1_funct7 : bus.req0_funct7;
    assign w_alu_funct3 = w_sel1 ? bus.req1_funct3 : bus.req0_funct3;
    assign w_alu_a      = w_sel1 ? bus.req1_a      : bus.req0_a;
    assign w_alu_b      = w_sel1 ? bus.req1_b      : bus.req0_b;

    alu_rr_arbiter_alu u_alu (
        .i_funct7 (w_alu_funct7),
        .i_funct3 (w_alu_funct3),
        .i_a      (w_alu_a),
        .i_b      (w_alu_b),
        .o_result (w_alu_result),
        .o_flags  (w_alu_flags)
    );

    // Round-robin pointer follows every grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= RESET_LAST;
        end else if (w_grant_valid) begin
            r_last_grant <= w_grant;
        end
    end

    // Response slot 0: refill wins over drain, data held otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp0_valid  <= 1'b0;
            r_rsp0_result <= '0;
            r_rsp0_flags  <= '0;
            r_rsp0_tag    <= '0;
        end else if (w_hs0) begin
            r_rsp0_valid  <= 1'b1;
            r_rsp0_result <= w_alu_result;
            r_rsp0_flags  <= w_alu_flags;
            r_rsp0_tag    <= bus.req0_tag;
        end else if (bus.rsp0_ready) begin
            r_rsp0_valid  <= 1'b0;
        end
    end

    // Response slot 1: refill wins over drain, data held otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp1_valid  <= 1'b0;
            r_rsp1_result <= '0;
            r_rsp1_flags  <= '0;
            r_rsp1_tag    <= '0;
        end else if (w_hs1) begin
            r_rsp1_valid  <= 1'b1;
            r_rsp1_result <= w_alu_result;
            r_rsp1_flags  <= w_alu_flags;
            r_rsp1_tag    <= bus.req1_tag;
        end else if (bus.rsp1_ready) begin
            r_rsp1_valid  <= 1'b0;
        end
    end

    assign bus.rsp0_valid  = r_rsp0_valid;
    assign bus.rsp0_result = r_rsp0_result;
    assign bus.rsp0_flags  = r_rsp0_flags;
    assign bus.rsp0_tag    = r_rsp0_tag;
    assign bus.rsp1_valid  = r_rsp1_valid;
    assign bus.rsp1_result = r_rsp1_result;
    assign bus.rsp1_flags  = r_rsp1_flags;
    assign bus.rsp1_tag    = r_rsp1_tag;

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_rr_arbiter
// Brief    : Self-checking bench for alu_rr_arbiter: directed steps plus a
//            per-requester scoreboard fed by an independent ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_rr_arbiter;

    localparam int TAG_W = 2;

    typedef struct packed {
        logic [6:0]       f7;
        logic [2:0]       f3;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
    } op_t;

    typedef struct packed {
        logic [31:0]      res;
        logic [3:0]       fl;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_asserts = 0;
    int   n_fail    = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    alu_rr_arbiter_if #(.TAG_W(TAG_W)) bus ();

    alu_rr_arbiter #(.TAG_W(TAG_W), .RESET_LAST(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference ALU written with wide signed/unsigned arithmetic
    function automatic exp_t model(input op_t op);
        exp_t        e;
        longint      sa, sb, wide;
        logic [32:0] u;
        logic [31:0] r;
        logic        sub;
        sub  = op.f7[5] || (op.f3 == 3'b010) || (op.f3 == 3'b011);
        sa   = longint'($signed(op.a));
        sb   = longint'($signed(op.b));
        wide = sub ? (sa - sb) : (sa + sb);
        u    = sub ? ({1'b0, op.a} - {1'b0, op.b}) : ({1'b0, op.a} + {1'b0, op.b});
        r    = u[31:0];
        e.fl[3] = (wide != longint'($signed(r)));
        e.fl[2] = sub ? ~u[32] : u[32];
        e.fl[1] = r[31];
        e.fl[0] = (r == 32'd0);
        case (op.f3)
            3'b000:  e.res = r;
            3'b001:  e.res = op.a << op.b[4:0];
            3'b010:  e.res = {31'd0, (sa < sb)};
            3'b011:  e.res = {31'd0, (op.a < op.b)};
            3'b100:  e.res = op.a ^ op.b;
            3'b101:  e.res = op.f7[5] ? 32'($signed(op.a) >>> op.b[4:0]) : (op.a >> op.b[4:0]);
            3'b110:  e.res = op.a | op.b;
            default: e.res = op.a & op.b;
        endcase
        e.tag = op.tag;
        return e;
    endfunction

    task automatic sb_port(input int p, input logic rv, input logic rr, input logic qv,
                           input logic qr, input op_t op, input logic [31:0] res,
                           input logic [3:0] fl, input logic [TAG_W-1:0] tg);
        exp_t e;
        int   n;
        n = (p == 0) ? q0.size() : q1.size();
        check($sformatf("rsp%0d_valid", p), 32'(rv), 32'(n != 0));
        if (rv && rr && (n != 0)) begin
            if (p == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check($sformatf("rsp%0d_result", p), res, e.res);
            check($sformatf("rsp%0d_flags", p), 32'(fl), 32'(e.fl));
            check($sformatf("rsp%0d_tag", p), 32'(tg), 32'(e.tag));
        end
        if (qv && qr) begin
            if (p == 0) q0.push_back(model(op));
            else        q1.push_back(model(op));
        end
    endtask

    // Scoreboard and grant-legality checks, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            sb_port(0, bus.rsp0_valid, bus.rsp0_ready, bus.req0_valid, bus.req0_ready,
                    op_t'({bus.req0_funct7, bus.req0_funct3, bus.req0_a, bus.req0_b, bus.req0_tag}),
                    bus.rsp0_result, bus.rsp0_flags, bus.rsp0_tag);
            sb_port(1, bus.rsp1_valid, bus.rsp1_ready, bus.req1_valid, bus.req1_ready,
                    op_t'({bus.req1_funct7, bus.req1_funct3, bus.req1_a, bus.req1_b, bus.req1_tag}),
                    bus.rsp1_result, bus.rsp1_flags, bus.rsp1_tag);
            check("ready_both", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
            check("ready0_inelig", 32'(bus.req0_ready &
                  ~(bus.req0_valid & (~bus.rsp0_valid | bus.rsp0_ready))), 32'd0);
            check("ready1_inelig", 32'(bus.req1_ready &
                  ~(bus.req1_valid & (~bus.rsp1_valid | bus.rsp1_ready))), 32'd0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input op_t op);
        bus.req0_funct7 = op.f7;
        bus.req0_funct3 = op.f3;
        bus.req0_a      = op.a;
        bus.req0_b      = op.b;
        bus.req0_tag    = op.tag;
    endtask

    task automatic drive1(input op_t op);
        bus.req1_funct7 = op.f7;
        bus.req1_funct3 = op.f3;
        bus.req1_a      = op.a;
        bus.req1_b      = op.b;
        bus.req1_tag    = op.tag;
    endtask

    initial begin
        op_t p0[4];
        op_t p1[4];
        int  i0;
        int  i1;

        p0[0] = '{7'h00, 3'b100, 32'hF0F0_0000, 32'h0FF0_1234, 2'd0};
        p0[1] = '{7'h00, 3'b110, 32'h00FF_00FF, 32'h1234_0000, 2'd1};
        p0[2] = '{7'h00, 3'b111, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 2'd2};
        p0[3] = '{7'h00, 3'b001, 32'h0000_0001, 32'hFFFF_FFFF, 2'd3};
        p1[0] = '{7'h20, 3'b101, 32'h8000_0000, 32'h0000_0004, 2'd0};
        p1[1] = '{7'h00, 3'b101, 32'h8000_0000, 32'h0000_0004, 2'd1};
        p1[2] = '{7'h00, 3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 2'd2};
        p1[3] = '{7'h20, 3'b000, 32'h0000_0000, 32'h0000_0001, 2'd3};

        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        drive0('0); drive1('0);

        // Reset state
        cyc(); cyc();
        check("rst_rsp0_valid",  32'(bus.rsp0_valid), 32'd0);
        check("rst_rsp1_valid",  32'(bus.rsp1_valid), 32'd0);
        check("rst_rsp0_result", bus.rsp0_result, 32'd0);
        check("rst_rsp0_flags",  32'(bus.rsp0_flags), 32'd0);
        check("rst_rsp1_result", bus.rsp1_result, 32'd0);
        check("rst_rsp1_tag",    32'(bus.rsp1_tag), 32'd0);
        rst = 1'b0;

        // Requester 0 ADD 5+3, accepted in the first cycle
        drive0('{7'h00, 3'b000, 32'd5, 32'd3, 2'd1});
        bus.req0_valid = 1'b1;
        #1;
        check("t1_ready0", 32'(bus.req0_ready), 32'd1);
        check("t1_ready1", 32'(bus.req1_ready), 32'd0);
        cyc();
        bus.req0_valid = 1'b0;
        #1;
        check("t1_rsp0_valid",  32'(bus.rsp0_valid), 32'd1);
        check("t1_rsp0_result", bus.rsp0_result, 32'h8);
        check("t1_rsp0_flags",  32'(bus.rsp0_flags), 32'h0);
        check("t1_rsp0_tag",    32'(bus.rsp0_tag), 32'd1);
        cyc();

        // Requester 1 SUB back-to-back
        drive1('{7'h20, 3'b000, 32'd3, 32'd5, 2'd2});
        bus.req1_valid = 1'b1;
        #1;
        check("t2_ready1a", 32'(bus.req1_ready), 32'd1);
        cyc();
        drive1('{7'h20, 3'b000, 32'd7, 32'd7, 2'd3});
        #1;
        check("t2_ready1b",      32'(bus.req1_ready), 32'd1);
        check("t2_rsp1_result1", bus.rsp1_result, 32'hFFFF_FFFE);
        check("t2_rsp1_flags1",  32'(bus.rsp1_flags), 32'b0010);
        cyc();
        bus.req1_valid = 1'b0;
        #1;
        check("t2_rsp1_valid2",  32'(bus.rsp1_valid), 32'd1);
        check("t2_rsp1_result2", bus.rsp1_result, 32'd0);
        check("t2_rsp1_flags2",  32'(bus.rsp1_flags), 32'b0101);
        cyc();

        // Both requesting: alternate 0,1,0,1 (requester 1 was granted last)
        i0 = 0; i1 = 0;
        for (int k = 0; k < 4; k++) begin
            drive0(p0[i0]); drive1(p1[i1]);
            bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
            #1;
            check($sformatf("t3_ready0_c%0d", k), 32'(bus.req0_ready), 32'((k % 2) == 0));
            check($sformatf("t3_ready1_c%0d", k), 32'(bus.req1_ready), 32'((k % 2) == 1));
            if ((k % 2) == 0) i0++;
            else              i1++;
            cyc();
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        cyc();

        // Stalled rsp1 must not block requester 0
        bus.rsp1_ready = 1'b0;
        drive1(p1[2]);
        bus.req1_valid = 1'b1;
        #1;
        check("t4_fill1", 32'(bus.req1_ready), 32'd1);
        cyc();
        drive1(p1[3]);
        for (int k = 0; k < 3; k++) begin
            drive0(p0[k]);
            bus.req0_valid = 1'b1;
            #1;
            check($sformatf("t4_ready0_c%0d", k), 32'(bus.req0_ready), 32'd1);
            check($sformatf("t4_ready1_c%0d", k), 32'(bus.req1_ready), 32'd0);
            cyc();
        end
        drive0(p0[3]);
        bus.rsp1_ready = 1'b1;
        #1;
        check("t4_release_ready1", 32'(bus.req1_ready), 32'd1);
        check("t4_release_ready0", 32'(bus.req0_ready), 32'd0);
        cyc();
        bus.req1_valid = 1'b0;
        #1;
        check("t4_late_ready0", 32'(bus.req0_ready), 32'd1);
        cyc();
        bus.req0_valid = 1'b0;
        cyc();

        // SLT / SLTU on the same operands
        drive0('{7'h00, 3'b010, 32'hFFFF_FFFF, 32'd1, 2'd1});
        bus.req0_valid = 1'b1;
        cyc();
        drive0('{7'h00, 3'b011, 32'hFFFF_FFFF, 32'd1, 2'd2});
        #1;
        check("t5_slt", bus.rsp0_result, 32'd1);
        cyc();
        bus.req0_valid = 1'b0;
        #1;
        check("t5_sltu", bus.rsp0_result, 32'd0);
        cyc();

        // Asynchronous reset with a stalled, full rsp0
        bus.rsp0_ready = 1'b0;
        drive0('{7'h00, 3'b000, 32'd1, 32'd1, 2'd2});
        bus.req0_valid = 1'b1;
        cyc();
        bus.req0_valid = 1'b0;
        #1;
        check("t6_full_before_rst", 32'(bus.rsp0_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("t6_async_drop", 32'(bus.rsp0_valid), 32'd0);
        check("t6_rst_result", bus.rsp0_result, 32'd0);
        check("t6_rst_tag",    32'(bus.rsp0_tag), 32'd0);
        cyc();
        #2;
        rst = 1'b0;
        bus.rsp0_ready = 1'b1;
        drive0('{7'h00, 3'b000, 32'd9, 32'd1, 2'd3});
        drive1('{7'h00, 3'b000, 32'd4, 32'd4, 2'd1});
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        check("t6_tie_ready0", 32'(bus.req0_ready), 32'd1);
        check("t6_tie_ready1", 32'(bus.req1_ready), 32'd0);
        cyc();
        bus.req0_valid = 1'b0;
        cyc();
        bus.req1_valid = 1'b0;
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
